// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Provides the circular priority search used by rr_arbiter8.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set bit of req, searched upward from (ptr+1) with wrap.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/decoder.sv
// 3-to-8 one-hot decoder with enable.
// Output is all-zero when en is low.
module decoder
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] i,
    input  logic             en,
    output logic [N_REQ-1:0] o
);

    always_comb begin
        o = '0;
        if (en) o[i] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter, IDLE/GRANT FSM, one idle cycle between grants.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] gnt
`ifdef ARB_TIMEOUT_EN
  , output logic             timeout
`endif
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("rr_arbiter8: HOLD_MAX must be in 1..255");
    end

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic             user_rel;
    logic             rel;

    assign gnt_vld  = (state == GRANT);
    assign user_rel = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] cnt;
    logic       to_hit;

    assign to_hit = (cnt == HOLD_LAST);
    assign rel    = user_rel | to_hit;
`else
    assign rel    = user_rel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= IDX_W'(N_REQ - 1);
            gnt_idx <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt     <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state   <= GRANT;
                        gnt_idx <= rr_pick(req, ptr);
`ifdef ARB_TIMEOUT_EN
                        cnt     <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state   <= IDLE;
                        ptr     <= gnt_idx;
                        gnt_idx <= '0;
`ifdef ARB_TIMEOUT_EN
                        timeout <= ~user_rel;
                        cnt     <= '0;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        cnt <= cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    decoder u_dec (
        .i  (gnt_idx),
        .en (gnt_vld),
        .o  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: expected grant order queued by stimulus,
// popped by a monitor on each new grant; directed checks cover idle/reset.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int n_cmp;
    int n_err;
    int exp_q[$];
    logic prev_vld;

`ifdef ARB_TIMEOUT_EN
    rr_arbiter8 #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .gnt     (gnt),
        .timeout (timeout)
    );
`else
    rr_arbiter8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .gnt     (gnt)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".vld"}, int'(gnt_vld), 0);
        chk({name, ".gnt"}, int'(gnt), 0);
        chk({name, ".idx"}, int'(gnt_idx), 0);
    endtask

    // Monitor: each new grant is matched against the scoreboard.
    always @(negedge clk) begin
        int e;
        logic [7:0] oh;
        if (gnt_vld && !prev_vld) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL mon.unexpected: got grant %0d expected none",
                         gnt_idx);
            end else begin
                e = exp_q.pop_front();
                if (int'(gnt_idx) != e) begin
                    n_err++;
                    $display("FAIL mon.order: got %0d expected %0d",
                             gnt_idx, e);
                end
            end
        end
        oh = 8'h00;
        if (gnt_vld) oh[gnt_idx] = 1'b1;
        n_cmp++;
        if (gnt != oh) begin
            n_err++;
            $display("FAIL mon.onehot: got %02h expected %02h", gnt, oh);
        end
        prev_vld = gnt_vld;
    end

    initial begin
        int order[9];
        n_cmp    = 0;
        n_err    = 0;
        prev_vld = 1'b0;
        rst_n    = 1'b0;
        req      = 8'h00;
        done     = 1'b0;
        #3;
        chk_idle("reset");
        step(2);
        rst_n = 1'b1;

        // Idle with no requests, done ignored
        step();
        chk_idle("idle0");
        done = 1'b1;
        step();
        done = 1'b0;
        chk_idle("idle_done");

        // Single requester 0, release via done + req drop together
        req = 8'h01;
        exp_q.push_back(0);
        step();
        chk("r0.vld", int'(gnt_vld), 1);
        chk("r0.gnt", int'(gnt), 8'h01);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;
        chk_idle("r0.rel");
        step();
        chk_idle("r0.stay");

        // All requests held: ptr=0, so order 1..7,0,1
        order = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            exp_q.push_back(order[g]);
            step();
            chk("ff.idx", int'(gnt_idx), order[g]);
            done = 1'b1;
            if (g == 8) req = 8'h00;
            step();
            done = 1'b0;
            chk_idle("ff.gap");
        end

        // Reach ptr=5 via request drop, then wrap past 7
        req = 8'h20;
        exp_q.push_back(5);
        step();
        chk("p5.idx", int'(gnt_idx), 5);
        req = 8'h00;
        step();
        chk_idle("p5.rel");
        req = 8'h21;
        exp_q.push_back(0);
        exp_q.push_back(5);
        step();
        chk("wrap.idx0", int'(gnt_idx), 0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk_idle("wrap.gap");
        step();
        chk("wrap.idx5", int'(gnt_idx), 5);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;
        chk_idle("wrap.rel");

        // Grant 3 holds through other req toggling, then drops req[3]
        req = 8'h08;
        exp_q.push_back(3);
        step();
        chk("g3.idx", int'(gnt_idx), 3);
        req = 8'h7B;
        step();
        chk("g3.hold1", int'(gnt), 8'h08);
        req = 8'h0F;
        step();
        chk("g3.hold2", int'(gnt_idx), 3);
        req = 8'h31;
        step();
        chk_idle("g3.drop");
        exp_q.push_back(4);
        step();
        chk("g3.next", int'(gnt_idx), 4);

`ifdef ARB_TIMEOUT_EN
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;
        // Held request with no done: forced release after 4 cycles
        req = 8'h04;
        exp_q.push_back(2);
        exp_q.push_back(2);
        step();
        for (int c = 0; c < 4; c++) begin
            chk("to.held", int'(gnt_vld), 1);
            chk("to.quiet", int'(timeout), 0);
            step();
        end
        chk_idle("to.rel");
        chk("to.pulse", int'(timeout), 1);
        step();
        chk("to.regrant", int'(gnt_idx), 2);
        chk("to.clear", int'(timeout), 0);
        chk("to.vld", int'(gnt_vld), 1);
`else
        // No timeout: grant held indefinitely
        step(20);
        chk("hold.vld", int'(gnt_vld), 1);
        chk("hold.idx", int'(gnt_idx), 4);
`endif

        // Asynchronous reset mid-grant
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("arst");
        req = 8'h80;
        step(2);
        chk_idle("arst.hold");
        rst_n = 1'b1;
        exp_q.push_back(7);
        step();
        chk("post.idx", int'(gnt_idx), 7);
        chk("post.gnt", int'(gnt), 8'h80);
        req = 8'h00;
        step();
        chk_idle("post.rel");
        step(2);

        chk("sb.empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: HOLD_MAX, default 15, maximum grant tenure in cycles (range 1..255); used only when ARB_TIMEOUT_EN is defined.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  single clock, rising-edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req  input  8  request vector, bit k = requester k.
REQ-006 Port: done  input  1  single-cycle release pulse from the current grantee.
REQ-007 Port: gnt_vld  output  1  a grant is active.
REQ-008 Port: gnt_idx  output  3  binary index of the grantee; 0 when gnt_vld=0.
REQ-009 Port: gnt  output  8  one-hot grant; all-zero when gnt_vld=0.
REQ-010 Port: timeout  output  1  one-cycle pulse on forced release; exists only with ARB_TIMEOUT_EN.

Function
REQ-011 FSM states: IDLE (no grant) and GRANT (grant held).
REQ-012 Arbitration: in IDLE with req!=0 at edge t, the block SHALL enter GRANT and present gnt_vld/gnt_idx/gnt registered at t+1, giving 1-cycle latency.
REQ-013 Winner: first set bit of req searched circularly from (ptr+1) mod 8 upward, where ptr is the last granted index.
REQ-014 In IDLE with req==0, the block SHALL remain in IDLE with outputs zero and ptr unchanged.
REQ-015 GRANT hold: gnt_idx/gnt SHALL stay stable regardless of other req bits.
REQ-016 Release conditions in GRANT (any one): done=1; req[gnt_idx]=0; timeout (REQ-026).
REQ-017 On release, ptr SHALL load gnt_idx, and the FSM SHALL return to IDLE for exactly one cycle with all grant outputs zero, so grants never overlap.
REQ-018 done asserted in IDLE SHALL be ignored.
REQ-019 Simultaneous done and req drop SHALL count as a single release.
REQ-020 Wrap-around: ptr=7 SHALL search from index 0.
REQ-021 gnt SHALL always equal the one-hot decode of gnt_idx gated by gnt_vld.
REQ-022 Fairness: with all 8 requests held continuously, each requester SHALL be granted exactly once per 8 grants.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, ptr=7 (first search starts at 0), gnt_vld=0, gnt_idx=0, gnt=0, hold counter=0, timeout=0.
REQ-024 Reset asserted during GRANT SHALL drop the grant asynchronously with no release pulse.
REQ-025 First arbitration after reset deassertion SHALL occur on the first rising edge at which req!=0.

Configuration
REQ-026 With macro ARB_TIMEOUT_EN defined: an 8-bit hold counter clears on grant entry and increments each GRANT cycle; when the counter reaches HOLD_MAX-1 without any other release, the block SHALL force release on the next edge and pulse timeout for that one cycle, with ptr updated as in REQ-017.
REQ-027 Without ARB_TIMEOUT_EN: no counter, no timeout port; grant held indefinitely until done or request drop.

Structure
REQ-028 Shared package arb_pkg: N_REQ=8, IDX_W=3, FSM state enum (IDLE, GRANT).
REQ-029 One sub-module: the existing 3-to-8 decoder (decoder) instantiated with i=gnt_idx, en=gnt_vld, o driving gnt.
REQ-030 The priority search is combinational; the state, ptr, gnt_idx, and counter are registered.

Verification
REQ-031 Reset, then req=8'h01 at edge t -> gnt_idx=0, gnt=8'h01, gnt_vld=1 at t+1; done pulse -> gnt=0 for 1 cycle.
REQ-032 req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0 with one IDLE cycle between grants.
REQ-033 ptr=5, req=8'h21 -> grant 0 (wrap past 7), then grant 5.
REQ-034 Grantee 3 drops req[3] with done=0 -> release, next grant goes to next requester above 3; other req toggling mid-grant leaves gnt unchanged.
REQ-035 ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h04 held, no done -> grant active exactly 4 cycles, timeout=1 for one cycle, re-grant to 2 after one IDLE cycle.
REQ-036 rst_n pulled low mid-GRANT, asynchronously to clk -> gnt/gnt_vld=0 immediately; after release, req=8'h80 -> grant 7 with ptr search starting at 0.
